regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU writeback and the load (memory) writeback.
- Uses a valid/ready handshake per requester, round-robin arbitration, and a one-cycle registered write stage driving the register file's write enable, write address and write data.
- Suppresses writes to register 0 and provides bypass-hit flags for two read addresses that match the write in flight.
- Keeps saturating per-requester commit counters for debug.

Parameters:
S_AD, 5, register address width
S_DATA, 32, register data width
CNT_W, 16, width of each saturating commit counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
hold  in  1  when 1, no request is granted this cycle
alu_valid  in  1  ALU writeback request
alu_addr  in  S_AD  ALU destination register
alu_data  in  S_DATA  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_addr  in  S_AD  load destination register
mem_data  in  S_DATA  loaded data
mem_ready  out  1  load request accepted this cycle
WE  out  1  register file write enable (registered)
AWR  out  S_AD  register file write address (registered)
DataIn  out  S_DATA  register file write data (registered)
rd_addr1  in  S_AD  decode read address 1
rd_addr2  in  S_AD  decode read address 2
byp_hit1  out  1  rd_addr1 matches the write in flight
byp_hit2  out  1  rd_addr2 matches the write in flight
alu_cnt  out  CNT_W  committed ALU writes, saturating
mem_cnt  out  CNT_W  committed load writes, saturating
zero_cnt  out  CNT_W  accepted writes to register 0 (dropped), saturating

Behaviour:
- Reset, synchronous, rst=1 at a rising edge:
  - WE=0, AWR=0, DataIn=0, all counters 0.
  - Priority pointer last_grant=MEM, so the ALU wins the first tie.
  - Any request presented in the same cycle as rst is not accepted.
- Ready outputs are combinational from valid, hold, last_grant and rst. A requester's ready never depends on its own ready.
- Grant rule, evaluated each cycle:
  - If hold=1 or rst=1: no grant.
  - Else if exactly one valid: grant it.
  - Else if both valid: grant the requester that is not last_grant.
  - Else: no grant.
- Acceptance means valid and ready in the same cycle. Only an accepted requester may change its addr/data. Unaccepted requests must be held stable by the source; the arbiter stores nothing for them.
- last_grant updates only on a grant. It is unchanged on idle cycles and hold cycles.
- Write stage latency is exactly 1 cycle. At the edge after acceptance:
  - AWR and DataIn take the accepted address and data.
  - WE=1 if the address is not 0.
  - If the address is 0: WE=0, zero_cnt increments, and AWR/DataIn still load.
- If there is no acceptance, WE=0 at the next edge and AWR/DataIn hold their values.
- Throughput is 1 write per cycle. The write port never backpressures, since the register file writes whenever WE=1.
- Counters:
  - alu_cnt or mem_cnt increments at the same edge that sets WE=1 for that requester's write.
  - Each counter saturates at all-ones and never wraps.
- Bypass:
  - byp_hitN = WE and (rd_addrN == AWR) and (rd_addrN != 0), combinational.
  - Decode uses DataIn as the bypass value when the flag is set.
- Simultaneous events:
  - hold overrides valid.
  - rst overrides hold and grant.
  - A hold asserted while WE=1 does not cancel the registered write already in flight.
- Reset mid-operation: the in-flight write is discarded (WE=0 next cycle), and requesters must re-present.

Test Plan:
- ALU only, alu_addr=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle WE=1, AWR=5, DataIn=0xDEADBEEF; alu_cnt=1.
- Both valid for 4 cycles (ALU addr 1..4, MEM addr 9..12, each advancing only on acceptance) from reset -> grants ALU,MEM,ALU,MEM; AWR sequence 1,9,2,10; alu_cnt=2, mem_cnt=2.
- mem_valid=1, mem_addr=0, mem_data=0x1234 -> mem_ready=1; next cycle WE=0, zero_cnt=1; mem_cnt unchanged; byp_hit1=0 with rd_addr1=0.
- Both valid with hold=1 for 3 cycles, then hold=0 -> no ready and WE=0 during hold; last_grant unchanged; on release, ALU (not last_grant) wins.
- Write to reg 7 in flight, rd_addr1=7, rd_addr2=8 -> byp_hit1=1, byp_hit2=0 in the WE=1 cycle, both 0 the following idle cycle.
- rst=1 for 1 cycle while both valid and a write is in flight -> no ready that cycle; next cycle WE=0 and counters 0; first tie after reset granted to ALU.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between the ALU writeback and
//   the load (memory) writeback. Requests are arbitrated round-robin and the
//   winner is written through a one-cycle registered write stage (WE/AWR/DataIn).
//   Writes to register 0 are accepted but never reach the register file.
//   Bypass-hit flags tell decode when a read address matches the write in flight.
//   Saturating commit counters are kept for debug visibility.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   hold                  blocks all grants for the current cycle
//   alu_valid/addr/data   ALU writeback request      -> alu_ready
//   mem_valid/addr/data   load writeback request     -> mem_ready
//   WE, AWR, DataIn       registered register-file write port
//   rd_addr1, rd_addr2    decode read addresses      -> byp_hit1, byp_hit2
//   alu_cnt, mem_cnt      committed (non-zero-address) writes per requester
//   zero_cnt              accepted writes to register 0 (dropped)
//
// Handshake: a request is accepted in the cycle where valid and ready are both
//   1. ready is combinational from both valids, hold, rst and the round-robin
//   pointer; it never depends on the requester's own ready. A source whose
//   request is not accepted must hold addr/data stable; nothing is buffered here.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int S_AD   = 5,
   parameter int S_DATA = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              alu_valid,
   input  logic [S_AD-1:0]   alu_addr,
   input  logic [S_DATA-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [S_AD-1:0]   mem_addr,
   input  logic [S_DATA-1:0] mem_data,
   output logic              mem_ready,
   output logic              WE,
   output logic [S_AD-1:0]   AWR,
   output logic [S_DATA-1:0] DataIn,
   input  logic [S_AD-1:0]   rd_addr1,
   input  logic [S_AD-1:0]   rd_addr2,
   output logic              byp_hit1,
   output logic              byp_hit2,
   output logic [CNT_W-1:0]  alu_cnt,
   output logic [CNT_W-1:0]  mem_cnt,
   output logic [CNT_W-1:0]  zero_cnt
);

   // Round-robin pointer: remembers who won the most recent grant.
   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;

   grant_t            last_grant;
   grant_t            last_grant_next;
   logic              grant_alu;
   logic              grant_mem;
   logic              accept;
   logic [S_AD-1:0]   sel_addr;
   logic [S_DATA-1:0] sel_data;
   logic              sel_zero;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) begin
         return c;
      end
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Grant / next-pointer logic. rst and hold both suppress every grant, so the
   // pointer only moves on a real acceptance.
   always_comb begin
      grant_alu       = 1'b0;
      grant_mem       = 1'b0;
      last_grant_next = last_grant;
      if (!rst && !hold) begin
         if (alu_valid && mem_valid) begin
            if (last_grant == GRANT_MEM) begin
               grant_alu = 1'b1;
            end else begin
               grant_mem = 1'b1;
            end
         end else if (alu_valid) begin
            grant_alu = 1'b1;
         end else if (mem_valid) begin
            grant_mem = 1'b1;
         end
      end
      if (grant_alu) begin
         last_grant_next = GRANT_ALU;
      end else if (grant_mem) begin
         last_grant_next = GRANT_MEM;
      end
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;
   assign accept    = grant_alu | grant_mem;
   assign sel_addr  = grant_alu ? alu_addr : mem_addr;
   assign sel_data  = grant_alu ? alu_data : mem_data;
   assign sel_zero  = (sel_addr == '0);

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_MEM;
      end else begin
         last_grant <= last_grant_next;
      end
   end

   // Registered write stage and commit counters. A register-0 write still loads
   // AWR/DataIn so the port reflects the last accepted request, but WE stays low.
   always_ff @(posedge clk) begin
      if (rst) begin
         WE       <= 1'b0;
         AWR      <= '0;
         DataIn   <= '0;
         alu_cnt  <= '0;
         mem_cnt  <= '0;
         zero_cnt <= '0;
      end else begin
         WE <= accept && !sel_zero;
         if (accept) begin
            AWR    <= sel_addr;
            DataIn <= sel_data;
         end
         if (accept && sel_zero) begin
            zero_cnt <= sat_inc(zero_cnt);
         end
         if (grant_alu && !sel_zero) begin
            alu_cnt <= sat_inc(alu_cnt);
         end
         if (grant_mem && !sel_zero) begin
            mem_cnt <= sat_inc(mem_cnt);
         end
      end
   end

   // Bypass: register 0 is never forwarded since it is never written.
   assign byp_hit1 = WE && (rd_addr1 == AWR) && (rd_addr1 != '0);
   assign byp_hit2 = WE && (rd_addr2 == AWR) && (rd_addr2 != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. A behavioural model tracks the
// expected write port, counters and round-robin preference; one process
// compares the DUT against it on every falling edge. Directed sequences add
// hand-computed literal checks. Counters use a narrow width so saturation is
// reachable in a short run.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int S_AD   = 5;
   localparam int S_DATA = 32;
   localparam int CNT_W  = 4;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst;
   logic              hold;
   logic              alu_valid;
   logic [S_AD-1:0]   alu_addr;
   logic [S_DATA-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [S_AD-1:0]   mem_addr;
   logic [S_DATA-1:0] mem_data;
   logic              mem_ready;
   logic              WE;
   logic [S_AD-1:0]   AWR;
   logic [S_DATA-1:0] DataIn;
   logic [S_AD-1:0]   rd_addr1;
   logic [S_AD-1:0]   rd_addr2;
   logic              byp_hit1;
   logic              byp_hit2;
   logic [CNT_W-1:0]  alu_cnt;
   logic [CNT_W-1:0]  mem_cnt;
   logic [CNT_W-1:0]  zero_cnt;

   regfile_write_arbiter #(
      .S_AD   (S_AD),
      .S_DATA (S_DATA),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .alu_valid (alu_valid),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .WE        (WE),
      .AWR       (AWR),
      .DataIn    (DataIn),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .byp_hit1  (byp_hit1),
      .byp_hit2  (byp_hit2),
      .alu_cnt   (alu_cnt),
      .mem_cnt   (mem_cnt),
      .zero_cnt  (zero_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_alu_pref: the ALU wins the next tie (i.e. the last grant went to MEM).
   bit                model_on = 1'b0;
   bit                m_alu_pref;
   bit                m_we;
   logic [S_AD-1:0]   m_awr;
   logic [S_DATA-1:0] m_data;
   int                m_alu_cnt;
   int                m_mem_cnt;
   int                m_zero_cnt;

   function automatic int sat(input int c);
      return (c >= MAXC) ? MAXC : c + 1;
   endfunction

   always @(negedge clk) begin
      bit                e_alu_rdy;
      bit                e_mem_rdy;
      logic [S_AD-1:0]   w_addr;
      logic [S_DATA-1:0] w_data;
      e_alu_rdy = !rst && !hold && alu_valid && (!mem_valid || m_alu_pref);
      e_mem_rdy = !rst && !hold && mem_valid && (!alu_valid || !m_alu_pref);
      if (model_on) begin
         chk("alu_ready", 64'(alu_ready), 64'(e_alu_rdy));
         chk("mem_ready", 64'(mem_ready), 64'(e_mem_rdy));
         chk("WE",        64'(WE),        64'(m_we));
         chk("AWR",       64'(AWR),       64'(m_awr));
         chk("DataIn",    64'(DataIn),    64'(m_data));
         chk("alu_cnt",   64'(alu_cnt),   64'(m_alu_cnt));
         chk("mem_cnt",   64'(mem_cnt),   64'(m_mem_cnt));
         chk("zero_cnt",  64'(zero_cnt),  64'(m_zero_cnt));
         chk("byp_hit1",  64'(byp_hit1),
             64'(m_we && rd_addr1 == m_awr && rd_addr1 != 0));
         chk("byp_hit2",  64'(byp_hit2),
             64'(m_we && rd_addr2 == m_awr && rd_addr2 != 0));
      end
      // Advance the model to what the next rising edge must produce.
      if (rst) begin
         model_on   = 1'b1;
         m_alu_pref = 1'b1;
         m_we       = 1'b0;
         m_awr      = '0;
         m_data     = '0;
         m_alu_cnt  = 0;
         m_mem_cnt  = 0;
         m_zero_cnt = 0;
      end else if (e_alu_rdy || e_mem_rdy) begin
         w_addr     = e_alu_rdy ? alu_addr : mem_addr;
         w_data     = e_alu_rdy ? alu_data : mem_data;
         m_awr      = w_addr;
         m_data     = w_data;
         m_we       = (w_addr != 0);
         m_alu_pref = e_mem_rdy;
         if (w_addr == 0)    m_zero_cnt = sat(m_zero_cnt);
         else if (e_alu_rdy) m_alu_cnt  = sat(m_alu_cnt);
         else                m_mem_cnt  = sat(m_mem_cnt);
      end else begin
         m_we = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      hold      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   int awr_q[$];
   int exp_awr[4] = '{1, 9, 2, 10};

   initial begin
      int ai;
      int mi;
      int next_ai;
      int next_mi;
      rst = 1'b1; hold = 1'b0;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset_WE",     64'(WE),       64'd0);
      chk("reset_AWR",    64'(AWR),      64'd0);
      chk("reset_DataIn", 64'(DataIn),   64'd0);
      chk("reset_cnt",    64'({alu_cnt, mem_cnt, zero_cnt}), 64'd0);
      tick();

      // ALU-only single write.
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1 chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      idle();
      #1;
      chk("t1_WE",      64'(WE),      64'd1);
      chk("t1_AWR",     64'(AWR),     64'd5);
      chk("t1_DataIn",  64'(DataIn),  64'hDEAD_BEEF);
      chk("t1_alu_cnt", 64'(alu_cnt), 64'd1);
      tick();

      // Both valid from reset: round-robin ALU, MEM, ALU, MEM.
      do_reset();
      ai = 1; mi = 9;
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1'b1; alu_addr = S_AD'(ai); alu_data = 32'hA000_0000 + 32'(ai);
         mem_valid = 1'b1; mem_addr = S_AD'(mi); mem_data = 32'hB000_0000 + 32'(mi);
         #1;
         next_ai = alu_ready ? ai + 1 : ai;
         next_mi = mem_ready ? mi + 1 : mi;
         tick();
         #1 awr_q.push_back(int'(AWR));
         ai = next_ai; mi = next_mi;
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_awr_seq%0d", k), 64'(awr_q[k]), 64'(exp_awr[k]));
      end
      chk("t2_alu_cnt", 64'(alu_cnt), 64'd2);
      chk("t2_mem_cnt", 64'(mem_cnt), 64'd2);
      tick();

      // Load write to register 0: accepted but dropped.
      mem_valid = 1'b1; mem_addr = '0; mem_data = 32'h1234; rd_addr1 = '0;
      #1 chk("t3_mem_ready", 64'(mem_ready), 64'd1);
      tick();
      idle();
      #1;
      chk("t3_WE",       64'(WE),       64'd0);
      chk("t3_zero_cnt", 64'(zero_cnt), 64'd1);
      chk("t3_mem_cnt",  64'(mem_cnt),  64'd2);
      chk("t3_byp_hit1", 64'(byp_hit1), 64'd0);
      chk("t3_DataIn",   64'(DataIn),   64'h1234);
      tick();

      // Hold for 3 cycles with both valid; last grant was MEM so ALU wins on release.
      alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h2020;
      mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'h2121;
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_hold_alu_rdy", 64'(alu_ready), 64'd0);
         chk("t4_hold_mem_rdy", 64'(mem_ready), 64'd0);
         tick();
         #1 chk("t4_hold_WE", 64'(WE), 64'd0);
      end
      hold = 1'b0;
      #1;
      chk("t4_rel_alu_rdy", 64'(alu_ready), 64'd1);
      chk("t4_rel_mem_rdy", 64'(mem_ready), 64'd0);
      tick();
      idle();
      #1 chk("t4_AWR", 64'(AWR), 64'd20);
      tick();

      // Bypass flags on a write to register 7; hold during flight does not cancel it.
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777;
      rd_addr1 = 5'd7; rd_addr2 = 5'd8;
      tick();
      idle();
      hold = 1'b1;
      #1;
      chk("t5_WE",       64'(WE),       64'd1);
      chk("t5_byp_hit1", 64'(byp_hit1), 64'd1);
      chk("t5_byp_hit2", 64'(byp_hit2), 64'd0);
      tick();
      hold = 1'b0;
      #1;
      chk("t5_idle_hit1", 64'(byp_hit1), 64'd0);
      chk("t5_idle_hit2", 64'(byp_hit2), 64'd0);
      tick();

      // Reset while both valid and a write in flight.
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333;
      tick();
      mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h4444;
      rd_addr1 = 5'd3;
      rst = 1'b1;
      #1;
      chk("t6_WE_inflight", 64'(WE),        64'd1);
      chk("t6_rst_alu_rdy", 64'(alu_ready), 64'd0);
      chk("t6_rst_mem_rdy", 64'(mem_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("t6_WE",       64'(WE),       64'd0);
      chk("t6_byp_hit1", 64'(byp_hit1), 64'd0);
      chk("t6_cnt",      64'({alu_cnt, mem_cnt, zero_cnt}), 64'd0);
      chk("t6_tie_alu",  64'(alu_ready), 64'd1);
      chk("t6_tie_mem",  64'(mem_ready), 64'd0);
      tick();
      idle();
      tick();

      // Saturation: 20 ALU writes and 18 register-0 loads.
      for (int k = 0; k < 20; k++) begin
         alu_valid = 1'b1; alu_addr = S_AD'(1 + (k % 31)); alu_data = 32'(k);
         tick();
      end
      idle();
      for (int k = 0; k < 18; k++) begin
         mem_valid = 1'b1; mem_addr = '0; mem_data = 32'(k + 100);
         tick();
      end
      idle();
      #1;
      chk("t7_alu_sat",  64'(alu_cnt),  64'(MAXC));
      chk("t7_zero_sat", 64'(zero_cnt), 64'(MAXC));
      chk("t7_mem_cnt",  64'(mem_cnt),  64'd0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
